updown_mod_counter: RTL



---
 rtl/counter_pkg.sv | 19 +
 rtl/tick_prescaler.sv | 42 ++++
 rtl/updown_mod_counter.sv | 90 +++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// ============================================================================
// counter_pkg : shared constants and helpers for the counter family
// Rev 1.0
// ============================================================================
`default_nettype none

package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Callers widen to 64 bits and truncate the result back to their own width.
  function automatic logic [63:0] clamp_load(input logic [63:0] value, input logic [63:0] max);
    return (value > max) ? max : value;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tick_prescaler.sv
// ============================================================================
// tick_prescaler : emits one tick every PRESCALE enabled cycles
// Rev 1.0
// ============================================================================
`default_nettype none

module tick_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic restart,
  output logic tick
);

  generate
    if (PRESCALE <= 1) begin : g_passthru
      logic w_unused;
      assign w_unused = &{1'b0, clk, reset, restart};
      assign tick     = en;
    end else begin : g_divider
      localparam int CNT_W = $clog2(PRESCALE);
      localparam logic [CNT_W-1:0] c_last = CNT_W'(PRESCALE - 1);

      logic [CNT_W-1:0] r_phase;

      assign tick = en && (r_phase == c_last);

      always_ff @(posedge clk) begin
        if (!reset || restart) begin
          r_phase <= '0;
        end else if (en) begin
          r_phase <= (r_phase == c_last) ? '0 : r_phase + CNT_W'(1);
        end
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/updown_mod_counter.sv
// ============================================================================
// updown_mod_counter : parametrised up/down modulo counter with prescaler,
//                      load/clear, wrap-or-saturate and sticky overflow
// Rev 1.0
// ============================================================================
`default_nettype none

module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = 2**WIDTH - 1,
  parameter int PRESCALE = 1,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] c_max = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_ovf;
  logic             w_tick;
  logic             w_event;
  logic [WIDTH-1:0] w_load_clamped;

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .restart (clear | load),
    .tick    (w_tick)
  );

  assign w_load_clamped = WIDTH'(clamp_load(64'(load_val), 64'(MAX_VAL)));

  // tc doubles as the "at boundary" test, so the compare happens before any
  // arithmetic and the count never visits values above MAX_VAL.
  assign tc      = (dir == DIR_UP) ? (r_count == c_max) : (r_count == '0);
  assign w_event = w_tick && tc && !clear && !load;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (clear) begin
        r_count <= '0;
      end else if (load) begin
        r_count <= w_load_clamped;
      end else if (w_tick) begin
        r_wrap <= tc;
        if (dir == DIR_UP) begin
          if (!tc)                r_count <= r_count + c_one;
          else if (SATURATE == 0) r_count <= '0;
        end else begin
          if (!tc)                r_count <= r_count - c_one;
          else if (SATURATE == 0) r_count <= c_max;
        end
      end

      if (w_event)      r_ovf <= 1'b1;
      else if (ovf_clr) r_ovf <= 1'b0;
    end
  end

  assign count = r_count;
  assign wrap  = r_wrap;
  assign ovf   = r_ovf;

endmodule

`default_nettype wire
